// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle core: word RAM with combinational read,
// plus a memory-mapped timer/LED/store-counter register bank.
module data_mem_responder #(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [15:0] MMIO_PAGE  = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  timer_irq,
    output logic [15:0]           led_out,
    output logic                  misalign_err
);

    localparam int unsigned RAM_WORDS = 1 << DEPTH_LOG2;
    localparam int unsigned LED_W     = 16;
    localparam int unsigned CTRL_W    = 3;

    localparam logic [5:0] REG_COUNT  = 6'd0;
    localparam logic [5:0] REG_CMP    = 6'd1;
    localparam logic [5:0] REG_CTRL   = 6'd2;
    localparam logic [5:0] REG_STATUS = 6'd3;
    localparam logic [5:0] REG_LED    = 6'd4;
    localparam logic [5:0] REG_SCNT   = 6'd5;

    logic [DATA_WIDTH-1:0] r_ram [RAM_WORDS];
    logic [DATA_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0] r_cmp;
    logic [CTRL_W-1:0]     r_ctrl;
    logic                  r_match;
    logic [LED_W-1:0]      r_led;
    logic [DATA_WIDTH-1:0] r_store_cnt;

    logic                  w_is_mmio;
    logic                  w_reg_hit;
    logic                  w_aligned;
    logic                  w_wr;
    logic                  w_ram_we;
    logic [DEPTH_LOG2-1:0] w_widx;
    logic [5:0]            w_reg_idx;
    logic                  w_wr_count;
    logic                  w_wr_cmp;
    logic                  w_wr_ctrl;
    logic                  w_wr_status;
    logic                  w_wr_led;
    logic                  w_match_hit;
    logic [DATA_WIDTH-1:0] w_count_nxt;
    logic [DATA_WIDTH-1:0] w_reg_rdata;

    // Address decode; misaligned accesses read the aligned word but never write
    always_comb begin
        w_is_mmio   = (addr[31:16] == MMIO_PAGE);
        w_reg_hit   = w_is_mmio && (addr[15:8] == 8'h00);
        w_aligned   = (addr[1:0] == 2'b00);
        w_wr        = we && w_aligned;
        w_ram_we    = w_wr && !w_is_mmio;
        w_widx      = addr[DEPTH_LOG2+1:2];
        w_reg_idx   = addr[7:2];
        w_wr_count  = w_wr && w_reg_hit && (w_reg_idx == REG_COUNT);
        w_wr_cmp    = w_wr && w_reg_hit && (w_reg_idx == REG_CMP);
        w_wr_ctrl   = w_wr && w_reg_hit && (w_reg_idx == REG_CTRL);
        w_wr_status = w_wr && w_reg_hit && (w_reg_idx == REG_STATUS);
        w_wr_led    = w_wr && w_reg_hit && (w_reg_idx == REG_LED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < RAM_WORDS; i++) begin
                r_ram[i] <= '0;
            end
        end else if (w_ram_we) begin
            r_ram[w_widx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_store_cnt <= '0;
        end else if (w_ram_we && (r_store_cnt != '1)) begin
            r_store_cnt <= r_store_cnt + DATA_WIDTH'(1);
        end
    end

    // Timer next state: a bus write to COUNT suppresses match evaluation that edge
    always_comb begin
        w_match_hit = 1'b0;
        w_count_nxt = r_count;
        if (w_wr_count) begin
            w_count_nxt = wdata;
        end else if (r_ctrl[0]) begin
            if (r_count == r_cmp) begin
                w_match_hit = 1'b1;
                w_count_nxt = r_ctrl[1] ? '0 : r_count + DATA_WIDTH'(1);
            end else begin
                w_count_nxt = r_count + DATA_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_cmp   <= '0;
            r_ctrl  <= '0;
            r_match <= 1'b0;
            r_led   <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_wr_cmp) begin
                r_cmp <= wdata;
            end
            if (w_wr_ctrl) begin
                r_ctrl <= wdata[CTRL_W-1:0];
            end
            if (w_wr_led) begin
                r_led <= wdata[LED_W-1:0];
            end
            // A fresh match beats a same-edge W1C clear
            if (w_match_hit) begin
                r_match <= 1'b1;
            end else if (w_wr_status && wdata[0]) begin
                r_match <= 1'b0;
            end
        end
    end

    always_comb begin
        w_reg_rdata = '0;
        if (w_reg_hit) begin
            case (w_reg_idx)
                REG_COUNT:  w_reg_rdata = r_count;
                REG_CMP:    w_reg_rdata = r_cmp;
                REG_CTRL:   w_reg_rdata = DATA_WIDTH'(r_ctrl);
                REG_STATUS: w_reg_rdata = DATA_WIDTH'(r_match);
                REG_LED:    w_reg_rdata = DATA_WIDTH'(r_led);
                REG_SCNT:   w_reg_rdata = r_store_cnt;
                default:    w_reg_rdata = '0;
            endcase
        end
    end

    always_comb begin
        rdata        = w_is_mmio ? w_reg_rdata : r_ram[w_widx];
        timer_irq    = r_match && r_ctrl[2];
        led_out      = r_led;
        misalign_err = !w_aligned;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: table of bus vectors plus timer/reset sequences.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        timer_irq;
    logic [15:0] led_out;
    logic        misalign_err;

    int n_checks = 0;
    int n_errors = 0;

    logic        e_irq;
    logic [15:0] e_led;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        irq;
        logic [15:0] led;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];

    data_mem_responder #(
        .DEPTH_LOG2(6),
        .DATA_WIDTH(32),
        .MMIO_PAGE (16'hFFFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .wdata       (wdata),
        .we          (we),
        .rdata       (rdata),
        .timer_irq   (timer_irq),
        .led_out     (led_out),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input string nm, input logic [31:0] rd);
        exp_t e;
        e.name = nm;
        e.rd   = rd;
        e.irq  = e_irq;
        e.led  = e_led;
        e.mis  = (addr[1:0] != 2'b00);
        exp_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty");
            return;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (rdata !== e.rd) begin
            n_errors++;
            $display("FAIL %s rdata got %h exp %h", e.name, rdata, e.rd);
        end
        n_checks++;
        if (timer_irq !== e.irq) begin
            n_errors++;
            $display("FAIL %s timer_irq got %b exp %b", e.name, timer_irq, e.irq);
        end
        n_checks++;
        if (led_out !== e.led) begin
            n_errors++;
            $display("FAIL %s led_out got %h exp %h", e.name, led_out, e.led);
        end
        n_checks++;
        if (misalign_err !== e.mis) begin
            n_errors++;
            $display("FAIL %s misalign_err got %b exp %b", e.name, misalign_err, e.mis);
        end
    endtask

    // One bus cycle: drive after the falling edge, check pre-edge outputs, edge follows
    task automatic cyc(input string nm, input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic [31:0] rd);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = w;
        push_exp(nm, rd);
        #1;
        check_pop();
        if (w && a == 32'hFFFF0010) e_led = d[15:0];
    endtask

    vec_t tbl [23];

    initial begin
        tbl[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000};
        tbl[1]  = '{32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{32'hFFFF_0014, 32'h0000_0000, 1'b0, 32'h0000_0001};
        tbl[3]  = '{32'h0000_0100, 32'h0000_1234, 1'b1, 32'h0000_0000};
        tbl[4]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_1234};
        tbl[5]  = '{32'h0000_0013, 32'h0000_0055, 1'b1, 32'hDEAD_BEEF};
        tbl[6]  = '{32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        tbl[7]  = '{32'hFFFF_0014, 32'h0000_0000, 1'b0, 32'h0000_0002};
        tbl[8]  = '{32'hFFFF_0010, 32'h1234_ABCD, 1'b1, 32'h0000_0000};
        tbl[9]  = '{32'hFFFF_0010, 32'h0000_0000, 1'b0, 32'h0000_ABCD};
        tbl[10] = '{32'hFFFF_0014, 32'h0000_0077, 1'b1, 32'h0000_0002};
        tbl[11] = '{32'hFFFF_0014, 32'h0000_0000, 1'b0, 32'h0000_0002};
        tbl[12] = '{32'hFFFF_0020, 32'h0000_0000, 1'b0, 32'h0000_0000};
        tbl[13] = '{32'hFFFF_0100, 32'h0000_0099, 1'b1, 32'h0000_0000};
        tbl[14] = '{32'hFFFF_0100, 32'h0000_0000, 1'b0, 32'h0000_0000};
        tbl[15] = '{32'hFFFF_0012, 32'h0000_0000, 1'b0, 32'h0000_ABCD};
        tbl[16] = '{32'h0000_0140, 32'h0000_CAFE, 1'b1, 32'h0000_0000};
        tbl[17] = '{32'h0000_0040, 32'h0000_0000, 1'b0, 32'h0000_CAFE};
        tbl[18] = '{32'hFFFF_0014, 32'h0000_0000, 1'b0, 32'h0000_0003};
        tbl[19] = '{32'hFFFF_0008, 32'hFFFF_FFF8, 1'b1, 32'h0000_0000};
        tbl[20] = '{32'hFFFF_0008, 32'h0000_0000, 1'b0, 32'h0000_0000};
        tbl[21] = '{32'hFFFF_0011, 32'h0000_FFFF, 1'b1, 32'h0000_ABCD};
        tbl[22] = '{32'hFFFF_0010, 32'h0000_0000, 1'b0, 32'h0000_ABCD};

        reset = 1'b0;
        addr  = 32'h0000_0010;
        wdata = '0;
        we    = 1'b0;
        e_irq = 1'b0;
        e_led = 16'h0000;

        #2;
        push_exp("reset_state", 32'h0);
        check_pop();
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 23; i++) begin
            cyc($sformatf("vec%0d", i), tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].rd);
        end

        // Auto-reload timer: CMP=5, enable|auto_reload|irq_en
        cyc("cmp_wr", 32'hFFFF_0004, 32'd5, 1'b1, 32'd0);
        cyc("ctrl_wr", 32'hFFFF_0008, 32'd7, 1'b1, 32'd0);
        for (int k = 0; k < 6; k++) begin
            cyc("cnt_run", 32'hFFFF_0000, 32'd0, 1'b0, 32'(k));
        end
        e_irq = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc("cnt_reload", 32'hFFFF_0000, 32'd0, 1'b0, 32'(k));
        end

        // W1C racing a new match: set wins, then a plain clear
        cyc("w1c_race", 32'hFFFF_000C, 32'd1, 1'b1, 32'd1);
        cyc("w1c_clr", 32'hFFFF_000C, 32'd1, 1'b1, 32'd1);
        e_irq = 1'b0;
        cyc("status_rd", 32'hFFFF_000C, 32'd0, 1'b0, 32'd0);
        cyc("ctrl_off", 32'hFFFF_0008, 32'd0, 1'b1, 32'd7);
        cyc("cnt_hold", 32'hFFFF_0000, 32'd0, 1'b0, 32'd3);
        cyc("cnt_hold", 32'hFFFF_0000, 32'd0, 1'b0, 32'd3);

        // Wrap-around with CMP=0, no auto-reload, no irq
        cyc("cmp0_wr", 32'hFFFF_0004, 32'd0, 1'b1, 32'd5);
        cyc("cnt_wr", 32'hFFFF_0000, 32'hFFFF_FFFE, 1'b1, 32'd3);
        cyc("ctrl_en", 32'hFFFF_0008, 32'd1, 1'b1, 32'd0);
        cyc("wrap_fe", 32'hFFFF_0000, 32'd0, 1'b0, 32'hFFFF_FFFE);
        cyc("wrap_ff", 32'hFFFF_0000, 32'd0, 1'b0, 32'hFFFF_FFFF);
        cyc("wrap_0", 32'hFFFF_0000, 32'd0, 1'b0, 32'd0);
        cyc("wrap_1", 32'hFFFF_0000, 32'd0, 1'b0, 32'd1);
        cyc("wrap_match", 32'hFFFF_000C, 32'd0, 1'b0, 32'd1);
        cyc("cnt_prio", 32'hFFFF_0000, 32'd7, 1'b1, 32'd3);
        cyc("cnt_prio_rd", 32'hFFFF_0000, 32'd0, 1'b0, 32'd7);
        cyc("status_clr", 32'hFFFF_000C, 32'd1, 1'b1, 32'd1);
        cyc("status_rd0", 32'hFFFF_000C, 32'd0, 1'b0, 32'd0);

        // Run timer with irq and LED set, then hit async reset between edges
        cyc("cmp3_wr", 32'hFFFF_0004, 32'd3, 1'b1, 32'd0);
        cyc("cnt0_wr", 32'hFFFF_0000, 32'd0, 1'b1, 32'd11);
        cyc("ctrl7_wr", 32'hFFFF_0008, 32'd7, 1'b1, 32'd1);
        cyc("led_wr", 32'hFFFF_0010, 32'h0000_A5A5, 1'b1, 32'h0000_ABCD);
        cyc("pre_rst_2", 32'hFFFF_0000, 32'd0, 1'b0, 32'd2);
        cyc("pre_rst_3", 32'hFFFF_0000, 32'd0, 1'b0, 32'd3);
        e_irq = 1'b1;
        cyc("pre_rst_0", 32'hFFFF_0000, 32'd0, 1'b0, 32'd0);

        @(negedge clk);
        #2;
        addr  = 32'hFFFF_000C;
        we    = 1'b0;
        reset = 1'b0;
        e_irq = 1'b0;
        e_led = 16'h0000;
        #1;
        push_exp("rst_status", 32'd0);
        check_pop();
        addr = 32'hFFFF_0000;
        #1;
        push_exp("rst_count", 32'd0);
        check_pop();
        @(posedge clk);
        #1;
        push_exp("rst_hold_cnt", 32'd0);
        check_pop();
        addr = 32'h0000_0010;
        #1;
        push_exp("rst_hold_ram", 32'd0);
        check_pop();
        @(negedge clk);
        reset = 1'b1;

        cyc("post_rst_0", 32'hFFFF_0000, 32'd0, 1'b0, 32'd0);
        cyc("post_rst_0b", 32'hFFFF_0000, 32'd0, 1'b0, 32'd0);
        cyc("post_ctrl", 32'hFFFF_0008, 32'd1, 1'b1, 32'd0);
        cyc("resume_0", 32'hFFFF_0000, 32'd0, 1'b0, 32'd0);
        cyc("resume_1", 32'hFFFF_0000, 32'd0, 1'b0, 32'd1);
        cyc("post_scnt", 32'hFFFF_0014, 32'd0, 1'b0, 32'd0);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
